// File: rtl/nonce_tx_queue_if.sv
// nonce_tx_queue_if -- bundle between the hashers, the serial core and the
// nonce transmit queue.
//
//   nonce_valid / nonce : golden nonce pulse and value from the hashers
//   tx_busy             : serial core is busy sending a 4-byte word
//   tx_ready / word     : one-cycle send request and the word to send
//   count / overflow    : FIFO occupancy and sticky drop flag
//
// Modports:
//   slave  - the queue side (nonce_tx_queue)
//   master - the environment side (hashers + serial core)
//
// DEPTH must match the DEPTH of the nonce_tx_queue it connects to, since it
// sets the width of count.
interface nonce_tx_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          nonce_valid;
  logic [31:0]   nonce;
  logic          tx_busy;
  logic          tx_ready;
  logic [31:0]   word;
  logic [CW-1:0] count;
  logic          overflow;

  modport slave (
    input  nonce_valid, nonce, tx_busy,
    output tx_ready, word, count, overflow
  );

  modport master (
    output nonce_valid, nonce, tx_busy,
    input  tx_ready, word, count, overflow
  );
endinterface

// File: rtl/nonce_tx_queue.sv
// nonce_tx_queue -- buffers golden nonces from the hashers in a circular FIFO
// and hands them, oldest first, to a serial core one 32-bit word at a time.
//
// Ports:
//   clk      - single clock
//   reset_n  - asynchronous active-low reset (release honoured synchronously)
//   bus      - nonce_tx_queue_if.slave: nonce_valid/nonce in, tx_busy in,
//              tx_ready/word/count/overflow out
//
// Parameter DEPTH: number of FIFO entries, power of two in 2..16.
//
// Build option: define NONCE_DEDUP_EN to silently drop a nonce equal to the
// most recently pushed one. Without it no compare logic is built.
//
// Sender FSM: IDLE -> ISSUE (one cycle, tx_ready=1, head popped) ->
// WAIT_BUSY (wait for tx_busy, give up after 4 idle cycles) ->
// WAIT_DONE (wait for tx_busy to drop) -> IDLE.
module nonce_tx_queue #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  nonce_tx_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Storage has no reset so it can map onto RAM; pointers/count define
  // which entries are live, so a reset discards the contents logically.
  logic [31:0] fifo_mem [DEPTH];

  state_t        state_q,    state_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic          overflow_q, overflow_d;
  logic          tx_ready_q, tx_ready_d;
  logic [31:0]   word_q,     word_d;
  logic [1:0]    guard_q,    guard_d;
  // Goes high on the first clock edge after reset release; pushes and issues
  // are blocked until then so the release edge itself does nothing.
  logic          run_q,      run_d;

  logic full;
  logic empty;
  logic pop;
  logic dup;
  logic push_req;
  logic push;
  logic drop;

`ifdef NONCE_DEDUP_EN
  logic [31:0] last_q,       last_d;
  logic        last_valid_q, last_valid_d;
`endif

  // ---------------------------------------------------------------- FIFO
  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    // The head leaves the FIFO during the single ISSUE cycle.
    pop   = (state_q == ISSUE);
`ifdef NONCE_DEDUP_EN
    dup   = last_valid_q && (bus.nonce == last_q);
`else
    dup   = 1'b0;
`endif
    push_req = run_q && bus.nonce_valid && !dup;
    // A full FIFO still accepts a nonce in the cycle the head is popped.
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;

    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | drop;
    run_d      = 1'b1;

`ifdef NONCE_DEDUP_EN
    last_d       = push ? bus.nonce : last_q;
    last_valid_d = last_valid_q | push;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.nonce;
    end
  end

  // ---------------------------------------------------------------- sender
  always_comb begin
    state_d    = state_q;
    tx_ready_d = 1'b0;
    word_d     = word_q;
    guard_d    = guard_q;
    unique case (state_q)
      IDLE: begin
        // tx_ready and word are registered, so the head is read here and
        // presented during ISSUE.
        if (run_q && !empty && !bus.tx_busy) begin
          state_d    = ISSUE;
          tx_ready_d = 1'b1;
          word_d     = fifo_mem[rd_ptr_q];
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        guard_d = 2'd0;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (guard_q == 2'd3) begin
          // Fourth idle cycle: the core missed the request; the word is
          // not re-sent.
          state_d = IDLE;
        end else begin
          guard_d = guard_q + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      tx_ready_q   <= 1'b0;
      word_q       <= '0;
      guard_q      <= '0;
      run_q        <= 1'b0;
`ifdef NONCE_DEDUP_EN
      last_q       <= '0;
      last_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      tx_ready_q   <= tx_ready_d;
      word_q       <= word_d;
      guard_q      <= guard_d;
      run_q        <= run_d;
`ifdef NONCE_DEDUP_EN
      last_q       <= last_d;
      last_valid_q <= last_valid_d;
`endif
    end
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.word     = word_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_nonce_tx_queue.sv
// tb_nonce_tx_queue -- directed self-checking bench for nonce_tx_queue
// (DEPTH=4). A small serial-core responder raises tx_busy a programmable
// number of cycles after each tx_ready; a monitor logs every issued word.
module tb_nonce_tx_queue;
  logic clk = 1'b0;
  logic reset_n = 1'b0;

  nonce_tx_queue_if #(.DEPTH(4)) bus ();

  nonce_tx_queue #(.DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Serial core model: busy from auto_d to auto_d+auto_l-1 cycles after tx_ready.
  logic busy_man  = 1'b0;
  logic busy_auto = 1'b0;
  bit   auto_en   = 1'b0;
  int   auto_d    = 1;
  int   auto_l    = 3;
  bit   auto_act  = 1'b0;
  int   auto_ctr  = 0;

  assign bus.tx_busy = busy_man | busy_auto;

  always @(negedge clk) begin
    if (bus.tx_ready && auto_en) begin
      auto_act = 1'b1;
      auto_ctr = 0;
    end else if (auto_act) begin
      auto_ctr = auto_ctr + 1;
    end
    busy_auto = auto_act && (auto_ctr >= auto_d) && (auto_ctr < auto_d + auto_l);
    if (auto_act && auto_ctr >= auto_d + auto_l) auto_act = 1'b0;
  end

  // Monitor of issued words.
  logic [31:0] sent_word [$];
  int          sent_cyc  [$];

  always @(negedge clk) begin
    if (bus.tx_ready) begin
      sent_word.push_back(bus.word);
      sent_cyc.push_back(cyc);
      $display("tx word=%08h cycle=%0d count=%0d", bus.word, cyc, bus.count);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [31:0] v);
    bus.nonce_valid = 1'b1;
    bus.nonce       = v;
    tick();
    bus.nonce_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    ticks(2);
  endtask

  int base;
  int nsent;
  logic [31:0] exp_w [$];

  initial begin
    bus.nonce_valid = 1'b0;
    bus.nonce       = '0;

    // ---- reset state
    ticks(2);
    check("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd0);
    check("rst_word",     bus.word, 32'd0);
    check("rst_count",    {29'd0, bus.count}, 32'd0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    #2 reset_n = 1'b1;
    ticks(3);

    // ---- single nonce, busy rises 3 cycles after tx_ready for 40 cycles
    auto_en = 1'b1; auto_d = 3; auto_l = 40;
    base = sent_word.size();
    push(32'hDEADBEEF);
    check("single_count1", {29'd0, bus.count}, 32'd1);
    check("single_rdy_lat1", {31'd0, bus.tx_ready}, 32'd0);
    tick();
    check("single_rdy_lat2", {31'd0, bus.tx_ready}, 32'd1);
    check("single_word", bus.word, 32'hDEADBEEF);
    tick();
    check("single_rdy_drop", {31'd0, bus.tx_ready}, 32'd0);
    check("single_count0", {29'd0, bus.count}, 32'd0);
    check("single_word_hold", bus.word, 32'hDEADBEEF);
    ticks(60);
    check("single_nsent", sent_word.size() - base, 32'd1);
    // Back in IDLE: a new nonce must issue exactly two cycles later.
    auto_d = 1; auto_l = 3;
    push(32'hCAFEF00D);
    tick();
    check("idle_again_rdy", {31'd0, bus.tx_ready}, 32'd1);
    check("idle_again_word", bus.word, 32'hCAFEF00D);
    ticks(10);

    // ---- five nonces into DEPTH=4 with tx_busy held
    busy_man = 1'b1;
    base = sent_word.size();
    for (int i = 1; i <= 4; i++) push(32'(i));
    check("fill_count", {29'd0, bus.count}, 32'd4);
    check("fill_ovf0", {31'd0, bus.overflow}, 32'd0);
    push(32'h5);
    check("drop_count", {29'd0, bus.count}, 32'd4);
    check("drop_ovf1", {31'd0, bus.overflow}, 32'd1);
    busy_man = 1'b0;
    ticks(40);
    check("drain_count", {29'd0, bus.count}, 32'd0);
    check("drain_ovf_sticky", {31'd0, bus.overflow}, 32'd1);
    check("drain_nsent", sent_word.size() - base, 32'd4);
    for (int i = 0; i < 4; i++) check("drain_order", sent_word[base + i], 32'(i + 1));

    // ---- full FIFO, push in the ISSUE cycle is accepted
    do_reset();
    check("reset_ovf_clear", {31'd0, bus.overflow}, 32'd0);
    busy_man = 1'b1;
    base = sent_word.size();
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(i));
    busy_man = 1'b0;
    tick();
    check("fullpop_issue", {31'd0, bus.tx_ready}, 32'd1);
    check("fullpop_word", bus.word, 32'h10);
    push(32'hA5A5A5A5);
    check("fullpop_count", {29'd0, bus.count}, 32'd4);
    check("fullpop_ovf", {31'd0, bus.overflow}, 32'd0);
    ticks(50);
    exp_w = '{32'h10, 32'h11, 32'h12, 32'h13, 32'hA5A5A5A5};
    check("fullpop_nsent", sent_word.size() - base, 32'd5);
    for (int i = 0; i < 5; i++) check("fullpop_order", sent_word[base + i], exp_w[i]);

    // ---- lost handshake: tx_busy never rises
    auto_en = 1'b0;
    do_reset();
    base = sent_word.size();
    push(32'h21);
    push(32'h22);
    check("lost_issue", {31'd0, bus.tx_ready}, 32'd1);
    ticks(20);
    check("lost_nsent", sent_word.size() - base, 32'd2);
    check("lost_w0", sent_word[base], 32'h21);
    check("lost_w1", sent_word[base + 1], 32'h22);
    check("lost_spacing", 32'(sent_cyc[base + 1] - sent_cyc[base]), 32'd6);
    check("lost_count", {29'd0, bus.count}, 32'd0);

    // ---- reset mid-WAIT_DONE with three queued
    busy_man = 1'b1;
    base = sent_word.size();
    for (int i = 0; i < 4; i++) push(32'h31 + 32'(i));
    auto_en = 1'b1; auto_d = 1; auto_l = 20;
    busy_man = 1'b0;
    tick();
    check("wd_issue_word", bus.word, 32'h31);
    ticks(3);
    check("wd_count3", {29'd0, bus.count}, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("async_count", {29'd0, bus.count}, 32'd0);
    check("async_tx_ready", {31'd0, bus.tx_ready}, 32'd0);
    check("async_word", bus.word, 32'd0);
    // Nonce offered across the release edge must be ignored.
    bus.nonce_valid = 1'b1;
    bus.nonce       = 32'h99;
    #2 reset_n = 1'b1;
    tick();
    bus.nonce_valid = 1'b0;
    check("release_no_push", {29'd0, bus.count}, 32'd0);
    ticks(40);
    check("abandon_nsent", sent_word.size() - base, 32'd1);
    check("abandon_count", {29'd0, bus.count}, 32'd0);

    // ---- repeated nonce 0x7, 0x7, 0x8
    auto_l = 3;
    base = sent_word.size();
    push(32'h7);
    push(32'h7);
    push(32'h8);
    ticks(40);
`ifdef NONCE_DEDUP_EN
    exp_w = '{32'h7, 32'h8};
`else
    exp_w = '{32'h7, 32'h7, 32'h8};
`endif
    nsent = sent_word.size() - base;
    check("dup_nsent", 32'(nsent), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++) check("dup_order", sent_word[base + i], exp_w[i]);
    check("dup_ovf", {31'd0, bus.overflow}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
